alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter: RS_DEPTH, default 8, number of entries; power of two, >= 4.
REQ-002 Parameter: PIPE_WIDTH, from uarch_pkg (2), maximum writes per cycle and CDB ports.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous mispredict flush; invalidates all entries.
REQ-006 alu_rs_rdy  output  PIPE_WIDTH  bit0: at least 1 entry free; bit1: at least 2 entries free.
REQ-007 alu_rs_we  input  PIPE_WIDTH  per-slot write enable from dispatch.
REQ-008 alu_rs_entries  input  instruction_t[PIPE_WIDTH]  renamed instructions; slot 0 is older than slot 1.
REQ-009 cdb_valid  input  PIPE_WIDTH  result broadcast valid per CDB port.
REQ-010 cdb_tag  input  TAG_WIDTH[PIPE_WIDTH]  ROB tag of the broadcast result.
REQ-011 cdb_data  input  XLEN[PIPE_WIDTH]  broadcast result value.
REQ-012 issue_valid  output  1  issue_inst holds a ready, valid entry.
REQ-013 issue_rdy  input  1  ALU accepts issue_inst this cycle.
REQ-014 issue_inst  output  instruction_t  selected entry with captured operands.

Function
REQ-015 alu_rs_rdy SHALL be derived combinationally from registered occupancy only; entries freed by this cycle's issue count from the next cycle.
REQ-016 Any alu_rs_we pattern (00, 01, 10, 11) SHALL be accepted; each set bit writes into the lowest-index free entry, with slot 0 taking the lower index when both are set.
REQ-017 Each written entry SHALL record an age stamp such that slot 0 is older than slot 1 and both are younger than all resident entries.
REQ-018 Writes in excess of free entries are a dispatch protocol violation; behaviour is undefined; an assertion SHALL flag it in simulation.
REQ-019 Each cycle, every valid entry with a non-ready source whose tag equals a valid cdb_tag SHALL capture the corresponding cdb_data and set that source ready.
REQ-020 An entry written in the same cycle as a matching CDB broadcast SHALL capture the broadcast value; no wakeup is lost.
REQ-021 An entry is eligible when valid and both sources are ready; issue_valid SHALL be high if and only if at least one entry is eligible, and SHALL be computed from registered state.
REQ-022 On issue_valid && issue_rdy, the selected entry SHALL be invalidated at the clock edge; exactly one issue occurs per cycle.
REQ-023 issue_inst SHALL remain stable while issue_valid && !issue_rdy unless an older entry becomes eligible.
REQ-024 A CDB wakeup SHALL make its entry eligible on the following cycle; write-to-issue latency is 1 cycle minimum.
REQ-025 flush SHALL invalidate all entries at the edge and take priority over same-cycle writes, wakeups, and issue.
REQ-026 Simultaneous issue and write in the same cycle SHALL both take effect; the freed index is not reused in that cycle.

Reset
REQ-027 rst SHALL clear all entry valid bits and age state immediately, independent of clk.
REQ-028 During and after reset: alu_rs_rdy = 2'b11, issue_valid = 0, issue_inst = all zeros.
REQ-029 Reset asserted mid-operation SHALL discard all entries, with no partial issue.

Configuration
REQ-030 Macro ALU_RS_OLDEST_FIRST_EN: when defined, selection SHALL pick the oldest eligible entry using the age stamps.
REQ-031 Without ALU_RS_OLDEST_FIRST_EN, selection SHALL pick the lowest-index eligible entry and the age logic SHALL be omitted.

Verification
REQ-032 Reset, then write both slots with ready operands -> next cycle issue_valid=1, slot 0 issues first, then slot 1 on the following cycle with issue_rdy=1.
REQ-033 Fill RS_DEPTH=8 entries with non-ready sources -> alu_rs_rdy=00; after 7 entries -> 01; after 6 -> 11.
REQ-034 Write entry with src_0 tag 5 while cdb_valid[1]=1, cdb_tag[1]=5, cdb_data[1]=0xDEAD -> entry issues next cycle with src_0 data 0xDEAD.
REQ-035 alu_rs_we=10 into an empty RS -> slot-1 instruction stored at index 0; alu_rs_rdy stays 11.
REQ-036 Four valid entries, flush=1 with alu_rs_we=11 in the same cycle -> next cycle the RS is empty, issue_valid=0, alu_rs_rdy=11.
REQ-037 With ALU_RS_OLDEST_FIRST_EN defined, entries at index 3 (older) and index 1 (younger) both eligible -> index 3 issues first; with the macro undefined -> index 1 issues first.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: out-of-order wakeup via CDB and single-issue select.
// Define ALU_RS_OLDEST_FIRST_EN for age-ordered selection; default is lowest-index.

package uarch_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned TAG_WIDTH  = 6;
  localparam int unsigned PIPE_WIDTH = 2;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] rob_tag;
    logic [3:0]           alu_op;
    logic                 src_0_rdy;
    logic [TAG_WIDTH-1:0] src_0_tag;
    logic [XLEN-1:0]      src_0_data;
    logic                 src_1_rdy;
    logic [TAG_WIDTH-1:0] src_1_tag;
    logic [XLEN-1:0]      src_1_data;
  } instruction_t;
endpackage

module alu_rs #(
  parameter int unsigned RS_DEPTH   = 8,
  parameter int unsigned PIPE_WIDTH = uarch_pkg::PIPE_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             flush,
  output logic [PIPE_WIDTH-1:0]                            alu_rs_rdy,
  input  logic [PIPE_WIDTH-1:0]                            alu_rs_we,
  input  uarch_pkg::instruction_t [PIPE_WIDTH-1:0]         alu_rs_entries,
  input  logic [PIPE_WIDTH-1:0]                            cdb_valid,
  input  logic [PIPE_WIDTH-1:0][uarch_pkg::TAG_WIDTH-1:0]  cdb_tag,
  input  logic [PIPE_WIDTH-1:0][uarch_pkg::XLEN-1:0]       cdb_data,
  output logic                                             issue_valid,
  input  logic                                             issue_rdy,
  output uarch_pkg::instruction_t                          issue_inst
);
  import uarch_pkg::instruction_t;

  localparam int unsigned IDX_W = $clog2(RS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);

  logic [RS_DEPTH-1:0]   valid_q;
  instruction_t          ent_q     [RS_DEPTH];
  instruction_t          ent_woke  [RS_DEPTH];
  instruction_t          ent_new   [PIPE_WIDTH];
  logic [CNT_W-1:0]      free_cnt;
  logic [RS_DEPTH-1:0]   taken;
  logic [IDX_W-1:0]      alloc_idx [PIPE_WIDTH];
  logic [PIPE_WIDTH-1:0] alloc_hit;
  logic [RS_DEPTH-1:0]   elig;
  logic [RS_DEPTH-1:0]   cand;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_found;
  logic                  fire;

  // Lower-numbered CDB port wins if two ports ever carry the same tag.
  function automatic instruction_t wake(input instruction_t e);
    instruction_t r;
    r = e;
    for (int p = PIPE_WIDTH - 1; p >= 0; p--) begin
      if (cdb_valid[p] && !e.src_0_rdy && e.src_0_tag == cdb_tag[p]) begin
        r.src_0_rdy  = 1'b1;
        r.src_0_data = cdb_data[p];
      end
      if (cdb_valid[p] && !e.src_1_rdy && e.src_1_tag == cdb_tag[p]) begin
        r.src_1_rdy  = 1'b1;
        r.src_1_data = cdb_data[p];
      end
    end
    return r;
  endfunction

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid_q[i]) free_cnt = free_cnt + CNT_W'(1);
    end
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      alu_rs_rdy[k] = (free_cnt >= CNT_W'(k + 1));
    end
  end

  // Allocation sees only registered occupancy, so a slot freed by issue is not reused this cycle.
  always_comb begin
    taken = '0;
    for (int s = 0; s < PIPE_WIDTH; s++) begin
      alloc_idx[s] = '0;
      alloc_hit[s] = 1'b0;
      if (alu_rs_we[s]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (!alloc_hit[s] && !valid_q[i] && !taken[i]) begin
            alloc_idx[s] = IDX_W'(i);
            alloc_hit[s] = 1'b1;
          end
        end
      end
      if (alloc_hit[s]) taken[alloc_idx[s]] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_woke[i] = wake(ent_q[i]);
      elig[i]     = valid_q[i] && ent_q[i].src_0_rdy && ent_q[i].src_1_rdy;
    end
    for (int s = 0; s < PIPE_WIDTH; s++) begin
      ent_new[s] = wake(alu_rs_entries[s]);
    end
  end

`ifdef ALU_RS_OLDEST_FIRST_EN
  // older_q[i][j] set means entry i was written before entry j.
  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      cand[i] = elig[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (j != i && elig[j] && older_q[j][i]) cand[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
    end else if (!flush) begin
      // Processing slots in order makes slot 0 older than slot 1.
      for (int s = 0; s < PIPE_WIDTH; s++) begin
        if (alloc_hit[s]) begin
          for (int j = 0; j < RS_DEPTH; j++) begin
            if (IDX_W'(j) != alloc_idx[s]) begin
              older_q[alloc_idx[s]][j] <= 1'b0;
              older_q[j][alloc_idx[s]] <= 1'b1;
            end
          end
        end
      end
    end
  end
`else
  always_comb cand = elig;
`endif

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cand[i] && !sel_found) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign issue_valid = |elig;
  assign issue_inst  = issue_valid ? ent_q[sel_idx] : '0;
  assign fire        = issue_valid && issue_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid_q[i]) ent_q[i] <= ent_woke[i];
      end
      if (fire) valid_q[sel_idx] <= 1'b0;
      for (int s = 0; s < PIPE_WIDTH; s++) begin
        if (alloc_hit[s]) begin
          valid_q[alloc_idx[s]] <= 1'b1;
          ent_q[alloc_idx[s]]   <= ent_new[s];
        end
      end
    end
  end

  // Dispatch must never write more entries than are free.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    $countones(alu_rs_we) <= int'(free_cnt))
    else $error("alu_rs: dispatch wrote more entries than free");

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic against
// an array-based reference model with per-entry age numbers.

module tb_alu_rs;
  import uarch_pkg::*;

  localparam int DEPTH = 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic [1:0]                    alu_rs_rdy;
  logic [1:0]                    alu_rs_we;
  instruction_t [1:0]            ents;
  logic [1:0]                    cdb_valid;
  logic [1:0][TAG_WIDTH-1:0]     cdb_tag;
  logic [1:0][XLEN-1:0]          cdb_data;
  logic                          issue_valid;
  logic                          issue_rdy;
  instruction_t                  issue_inst;

  alu_rs #(.RS_DEPTH(DEPTH), .PIPE_WIDTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alu_rs_rdy     (alu_rs_rdy),
    .alu_rs_we      (alu_rs_we),
    .alu_rs_entries (ents),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .issue_valid    (issue_valid),
    .issue_rdy      (issue_rdy),
    .issue_inst     (issue_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    instruction_t inst;
    int unsigned  age;
  } ment_t;

  ment_t       m [DEPTH];
  int unsigned seq;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (!m[i].v) n++;
    return n;
  endfunction

  function automatic int m_sel();
    int s = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].inst.src_0_rdy && m[i].inst.src_1_rdy) begin
`ifdef ALU_RS_OLDEST_FIRST_EN
        if (s < 0 || m[i].age < m[s].age) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    return s;
  endfunction

  function automatic instruction_t m_wake(input instruction_t e);
    instruction_t r = e;
    for (int p = 0; p < 2; p++) begin
      if (cdb_valid[p] && !r.src_0_rdy && e.src_0_tag == cdb_tag[p]) begin
        r.src_0_rdy = 1'b1; r.src_0_data = cdb_data[p];
      end
      if (cdb_valid[p] && !r.src_1_rdy && e.src_1_tag == cdb_tag[p]) begin
        r.src_1_rdy = 1'b1; r.src_1_data = cdb_data[p];
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
  endtask

  // One clock: compare outputs against the model, then advance the model.
  task automatic step();
    int    sel;
    int    nfree;
    bit    used [DEPTH];
    ment_t nm [DEPTH];
    @(negedge clk);
    sel   = m_sel();
    nfree = m_free();
    chk("rdy", 128'(alu_rs_rdy), 128'({nfree >= 2, nfree >= 1}));
    chk("issue_valid", 128'(issue_valid), 128'(sel >= 0));
    if (sel >= 0) chk("issue_inst", 128'(issue_inst), 128'(m[sel].inst));
    if (flush) begin
      model_clear();
    end else begin
      nm = m;
      for (int i = 0; i < DEPTH; i++) begin
        used[i] = m[i].v;
        if (m[i].v) nm[i].inst = m_wake(m[i].inst);
      end
      if (sel >= 0 && issue_rdy) nm[sel].v = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (alu_rs_we[s]) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (!used[i]) begin
              used[i]     = 1'b1;
              nm[i].v     = 1'b1;
              nm[i].inst  = m_wake(ents[s]);
              nm[i].age   = seq;
              seq++;
              break;
            end
          end
        end
      end
      m = nm;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_rs_we = 2'b00; cdb_valid = 2'b00; flush = 1'b0; issue_rdy = 1'b0;
    ents = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  function automatic instruction_t mk(input int rob, input bit r0, input int t0,
                                      input logic [31:0] d0);
    instruction_t e;
    e = '0;
    e.rob_tag    = TAG_WIDTH'(rob);
    e.alu_op     = 4'(rob);
    e.src_0_rdy  = r0;
    e.src_0_tag  = TAG_WIDTH'(t0);
    e.src_0_data = d0;
    e.src_1_rdy  = 1'b1;
    e.src_1_data = 32'h1000 + 32'(rob);
    return e;
  endfunction

  function automatic instruction_t rnd_ent();
    instruction_t e;
    e.rob_tag    = TAG_WIDTH'($urandom);
    e.alu_op     = 4'($urandom);
    e.src_0_rdy  = $urandom_range(0, 1) == 1;
    e.src_0_tag  = TAG_WIDTH'($urandom_range(0, 7));
    e.src_0_data = $urandom;
    e.src_1_rdy  = $urandom_range(0, 1) == 1;
    e.src_1_tag  = TAG_WIDTH'($urandom_range(0, 7));
    e.src_1_data = $urandom;
    return e;
  endfunction

  task automatic rand_inputs();
    int nfree = m_free();
    int t0;
    alu_rs_we = 2'($urandom_range(0, 3));
    if (nfree == 0) alu_rs_we = 2'b00;
    else if (nfree == 1 && alu_rs_we == 2'b11) alu_rs_we = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    ents[0]     = rnd_ent();
    ents[1]     = rnd_ent();
    cdb_valid   = 2'($urandom_range(0, 3));
    t0          = $urandom_range(0, 7);
    cdb_tag[0]  = TAG_WIDTH'(t0);
    cdb_tag[1]  = TAG_WIDTH'((t0 + 1 + $urandom_range(0, 6)) % 8);
    cdb_data[0] = $urandom;
    cdb_data[1] = $urandom;
    issue_rdy   = $urandom_range(0, 3) != 0;
    flush       = $urandom_range(0, 40) == 0;
  endtask

  initial begin
    seq = 0;
    model_clear();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 128'(alu_rs_rdy), 128'(2'b11));
    chk("rst_valid", 128'(issue_valid), 128'(0));
    chk("rst_inst", 128'(issue_inst), 128'(0));
    rst = 1'b0;

    // Two ready writes: slot 0 issues first, then slot 1.
    alu_rs_we = 2'b11; ents[0] = mk(1, 1, 0, 32'h11); ents[1] = mk(2, 1, 0, 32'h22);
    step();
    chk("dual_valid", 128'(issue_valid), 128'(1));
    chk("dual_first", 128'(issue_inst.rob_tag), 128'(1));
    idle(); issue_rdy = 1'b1;
    step();
    chk("dual_second", 128'(issue_inst.rob_tag), 128'(2));
    step();
    chk("dual_empty", 128'(issue_valid), 128'(0));

    // Slot-1-only write lands at index 0, ahead of a later index-1 write.
    idle(); alu_rs_we = 2'b10; ents[1] = mk(7, 0, 30, 0);
    step();
    chk("we10_rdy", 128'(alu_rs_rdy), 128'(2'b11));
    idle(); alu_rs_we = 2'b01; ents[0] = mk(8, 1, 0, 32'h8);
    cdb_valid = 2'b01; cdb_tag[0] = 6'd30; cdb_data[0] = 32'hBEEF;
    step();
    chk("we10_idx0", 128'(issue_inst.rob_tag), 128'(7));
    chk("we10_wake", 128'(issue_inst.src_0_data), 128'(32'hBEEF));
    idle(); issue_rdy = 1'b1;
    step(); step();

    // Occupancy thresholds.
    idle();
    for (int k = 0; k < 3; k++) begin
      alu_rs_we = 2'b11; ents[0] = mk(40 + k, 0, 50, 0); ents[1] = mk(44 + k, 0, 50, 0);
      step();
    end
    chk("occ6", 128'(alu_rs_rdy), 128'(2'b11));
    alu_rs_we = 2'b01; ents[0] = mk(48, 0, 50, 0);
    step();
    chk("occ7", 128'(alu_rs_rdy), 128'(2'b01));
    alu_rs_we = 2'b01; ents[0] = mk(49, 0, 50, 0);
    step();
    chk("occ8", 128'(alu_rs_rdy), 128'(2'b00));
    idle(); flush = 1'b1;
    step();

    // Flush beats a same-cycle dual write with four residents.
    idle();
    for (int k = 0; k < 2; k++) begin
      alu_rs_we = 2'b11; ents[0] = mk(10 + k, 1, 0, 0); ents[1] = mk(12 + k, 0, 51, 0);
      step();
    end
    flush = 1'b1; issue_rdy = 1'b1; alu_rs_we = 2'b11;
    ents[0] = mk(14, 1, 0, 0); ents[1] = mk(15, 1, 0, 0);
    step();
    chk("flush_rdy", 128'(alu_rs_rdy), 128'(2'b11));
    chk("flush_valid", 128'(issue_valid), 128'(0));

    // Write-cycle CDB capture.
    idle(); alu_rs_we = 2'b01; ents[0] = mk(20, 0, 5, 0);
    cdb_valid = 2'b10; cdb_tag[1] = 6'd5; cdb_data[1] = 32'hDEAD;
    step();
    chk("cdb_same_valid", 128'(issue_valid), 128'(1));
    chk("cdb_same_data", 128'(issue_inst.src_0_data), 128'(32'hDEAD));
    idle(); issue_rdy = 1'b1;
    step();

    // Older entry at index 3, younger at index 1, woken together.
    idle(); alu_rs_we = 2'b11; ents[0] = mk(30, 0, 20, 0); ents[1] = mk(31, 1, 0, 0);
    step();
    alu_rs_we = 2'b11; ents[0] = mk(32, 0, 20, 0); ents[1] = mk(33, 0, 21, 0);
    issue_rdy = 1'b1;
    step();
    idle(); alu_rs_we = 2'b01; ents[0] = mk(34, 0, 21, 0);
    step();
    idle(); cdb_valid = 2'b01; cdb_tag[0] = 6'd21; cdb_data[0] = 32'h2121;
    step();
`ifdef ALU_RS_OLDEST_FIRST_EN
    chk("age_pick", 128'(issue_inst.rob_tag), 128'(33));
`else
    chk("age_pick", 128'(issue_inst.rob_tag), 128'(34));
`endif
    idle(); issue_rdy = 1'b1;
    step();
`ifdef ALU_RS_OLDEST_FIRST_EN
    chk("age_next", 128'(issue_inst.rob_tag), 128'(34));
`else
    chk("age_next", 128'(issue_inst.rob_tag), 128'(33));
`endif
    idle(); flush = 1'b1;
    step();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset mid-operation.
    rand_inputs();
    rst = 1'b1;
    #2;
    chk("arst_rdy", 128'(alu_rs_rdy), 128'(2'b11));
    chk("arst_valid", 128'(issue_valid), 128'(0));
    chk("arst_inst", 128'(issue_inst), 128'(0));
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    for (int c = 0; c < 800; c++) begin
      rand_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
